// File: rtl/nfca_rx_framer.sv
// nfca_rx_framer
//   Collects one NFC-A PICC response frame from the bit-to-byte stage into a
//   local buffer while running CRC_A over every stored full byte. Once the
//   end beat arrives, the frame is drained as a valid/ready byte stream:
//   status header, length, then the buffered bytes.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   rx_tvalid/tdata/tdatab   byte beat, its data and number of valid bits
//   rx_tend, rx_terr         end-of-frame beat, frame ended with an error
//   m_tvalid/tready          output byte stream handshake
//   m_tdata, m_tlast         output byte, last byte of the output frame
//   busy                     a frame is held; the controller keeps rx off
//   rx_drop                  registered pulse: a beat arrived while busy
module nfca_rx_framer #(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_tvalid,
  input  logic [7:0] rx_tdata,
  input  logic [3:0] rx_tdatab,
  input  logic       rx_tend,
  input  logic       rx_terr,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic [7:0] m_tdata,
  output logic       m_tlast,
  output logic       busy,
  output logic       rx_drop
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_B = 8'(DEPTH);

  typedef enum logic [1:0] {COLLECT, HDR, LEN, DATA} state_t;

  state_t      state, state_nxt;
  logic [7:0]  count;
  logic [7:0]  rd_idx;
  logic [15:0] crc;
  logic        err, col, ovf;
  logic [3:0]  lastbits;
  logic [7:0]  buf_mem [0:DEPTH-1];

  logic beat, has_bits, room, store, hs, last_hs, crc_ok;

  // Byte-wise CRC_A step (reflected CCITT, no final xor).
  function automatic logic [15:0] crc_a_upd(input logic [15:0] c, input logic [7:0] d);
    logic [7:0]  ch;
    logic [15:0] cw;
    ch = d ^ c[7:0];
    ch = ch ^ (ch << 4);
    cw = {8'h00, ch};
    return (c >> 8) ^ (cw << 8) ^ (cw << 3) ^ (cw >> 4);
  endfunction

  assign beat     = rx_tvalid && (state == COLLECT);
  assign has_bits = (rx_tdatab != 4'd0);
  assign room     = (count < DEPTH_B);
  assign store    = beat && has_bits && room;
  assign hs       = m_tvalid && m_tready;
  // m_tlast is only ever raised on the length byte (empty frame) or the
  // final data byte, so a handshake on it closes the frame.
  assign last_hs  = hs && m_tlast;
  assign crc_ok   = (crc == 16'h0000) && (count >= 8'd3) && (lastbits == 4'd8) &&
                    !err && !col && !ovf;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= COLLECT;
    else     state <= state_nxt;
  end

  // next state
  always_comb begin
    state_nxt = state;
    case (state)
      COLLECT: if (beat && rx_tend) state_nxt = HDR;
      HDR:     if (hs) state_nxt = LEN;
      LEN:     if (hs) state_nxt = (count == 8'd0) ? COLLECT : DATA;
      DATA:    if (last_hs) state_nxt = COLLECT;
      default: state_nxt = COLLECT;
    endcase
  end

  // outputs
  always_comb begin
    m_tvalid = (state != COLLECT);
    busy     = (state != COLLECT);
    m_tdata  = 8'h00;
    m_tlast  = 1'b0;
    case (state)
      HDR:  m_tdata = {crc_ok, err, col, ovf, lastbits};
      LEN: begin
        m_tdata = count;
        m_tlast = (count == 8'd0);
      end
      DATA: begin
        m_tdata = buf_mem[rd_idx[AW-1:0]];
        m_tlast = (rd_idx == count - 8'd1);
      end
      default: ;
    endcase
  end

  // frame bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= 8'd0;
      rd_idx   <= 8'd0;
      crc      <= 16'h6363;
      err      <= 1'b0;
      col      <= 1'b0;
      ovf      <= 1'b0;
      lastbits <= 4'd0;
      rx_drop  <= 1'b0;
    end else begin
      rx_drop <= rx_tvalid && (state != COLLECT);

      if (beat) begin
        if (has_bits) begin
          if (room) begin
            count    <= count + 8'd1;
            lastbits <= rx_tdatab;
          end else begin
            ovf <= 1'b1;   // sticky until the frame is drained
          end
        end
        if (store && rx_tdatab == 4'd8) crc <= crc_a_upd(crc, rx_tdata);
        // a non-end beat carrying fewer than 8 bits marks the collision point
        if (!rx_tend && rx_tdatab != 4'd8) col <= 1'b1;
        if (rx_tend) err <= rx_terr;
      end

      if (state == LEN)     rd_idx <= 8'd0;
      else if (state == DATA && hs) rd_idx <= rd_idx + 8'd1;

      if (last_hs) begin
        count    <= 8'd0;
        crc      <= 16'h6363;
        err      <= 1'b0;
        col      <= 1'b0;
        ovf      <= 1'b0;
        lastbits <= 4'd0;
      end
    end
  end

  // frame buffer, no reset needed: count gates what is ever read back
  always_ff @(posedge clk) begin
    if (store) buf_mem[count[AW-1:0]] <= rx_tdata;
  end

endmodule

// File: tb/tb_nfca_rx_framer.sv
module tb_nfca_rx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // index 0: DEPTH=32 instance, index 1: DEPTH=4 instance
  logic       rst       [2];
  logic       rx_tvalid [2];
  logic [7:0] rx_tdata  [2];
  logic [3:0] rx_tdatab [2];
  logic       rx_tend   [2];
  logic       rx_terr   [2];
  logic       m_tready  [2];
  logic       m_tvalid  [2];
  logic [7:0] m_tdata   [2];
  logic       m_tlast   [2];
  logic       busy      [2];
  logic       rx_drop   [2];

  nfca_rx_framer #(.DEPTH(32)) u_dut (
    .clk(clk), .rst(rst[0]), .rx_tvalid(rx_tvalid[0]), .rx_tdata(rx_tdata[0]),
    .rx_tdatab(rx_tdatab[0]), .rx_tend(rx_tend[0]), .rx_terr(rx_terr[0]),
    .m_tvalid(m_tvalid[0]), .m_tready(m_tready[0]), .m_tdata(m_tdata[0]),
    .m_tlast(m_tlast[0]), .busy(busy[0]), .rx_drop(rx_drop[0]));

  nfca_rx_framer #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst[1]), .rx_tvalid(rx_tvalid[1]), .rx_tdata(rx_tdata[1]),
    .rx_tdatab(rx_tdatab[1]), .rx_tend(rx_tend[1]), .rx_terr(rx_terr[1]),
    .m_tvalid(m_tvalid[1]), .m_tready(m_tready[1]), .m_tdata(m_tdata[1]),
    .m_tlast(m_tlast[1]), .busy(busy[1]), .rx_drop(rx_drop[1]));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_buf[$];
  logic [7:0] m_crcq[$];
  bit         m_err, m_col, m_ovf;
  int         m_lastbits;
  int         m_depth;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  // bit-serial CRC_A: reflected poly 0x8408, preset 0x6363
  function automatic logic [15:0] crc_of(input logic [7:0] q[$]);
    logic [15:0] c = 16'h6363;
    foreach (q[i]) begin
      c ^= {8'h00, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  task automatic model_reset(input int depth);
    m_buf.delete(); m_crcq.delete();
    m_err = 0; m_col = 0; m_ovf = 0; m_lastbits = 0; m_depth = depth;
  endtask

  task automatic model_beat(input logic [7:0] d, input int nb, input bit tend, input bit terr);
    bit stored = 0;
    if (nb != 0) begin
      if (m_buf.size() < m_depth) begin
        m_buf.push_back(d); stored = 1; m_lastbits = nb;
      end else m_ovf = 1;
    end
    if (nb == 8 && stored) m_crcq.push_back(d);
    if (!tend && nb != 8) m_col = 1;
    if (tend) m_err = terr;
  endtask

  task automatic build_exp();
    logic [15:0] c;
    bit ok;
    c  = crc_of(m_crcq);
    ok = (c == 16'h0) && (m_buf.size() >= 3) && (m_lastbits == 8) && !m_err && !m_col && !m_ovf;
    exp_q.delete();
    exp_q.push_back({ok, m_err, m_col, m_ovf, 4'(m_lastbits)});
    exp_q.push_back(8'(m_buf.size()));
    foreach (m_buf[i]) exp_q.push_back(m_buf[i]);
  endtask

  // ---------------- stimulus ----------------
  task automatic beat(input int d, input logic [7:0] data, input int nb, input bit tend, input bit terr);
    @(negedge clk);
    chk("idle_vld", m_tvalid[d], 1'b0);
    rx_tvalid[d] = 1'b1; rx_tdata[d] = data; rx_tdatab[d] = 4'(nb);
    rx_tend[d] = tend; rx_terr[d] = terr;
    model_beat(data, nb, tend, terr);
    @(negedge clk);
    rx_tvalid[d] = 1'b0; rx_tend[d] = 1'b0; rx_terr[d] = 1'b0; rx_tdatab[d] = 4'd0;
    if (tend) begin
      chk("hdr_vld_n1", m_tvalid[d], 1'b1);
      chk("busy_n1", busy[d], 1'b1);
    end
  endtask

  task automatic send_bytes(input int d, input logic [7:0] q[$]);
    foreach (q[i]) beat(d, q[i], 8, 1'b0, 1'b0);
  endtask

  // Drains the expected stream; entered at the negedge right after the end beat.
  task automatic drain(input int d, input int rdy_pct, input bit inject, input int rst_after);
    int idx = 0, inj = 0, drops = 0, cyc = 0;
    bit held_v = 0, held_l = 0, rdy;
    logic [7:0] held_d = 8'h00;
    got_q.delete();
    while (idx < exp_q.size() && cyc < 2000) begin
      if (rx_drop[d]) drops++;
      chk("drain_vld", m_tvalid[d], 1'b1);
      chk("drain_busy", busy[d], 1'b1);
      if (held_v) begin
        chk("hold_data", m_tdata[d], held_d);
        chk("hold_last", m_tlast[d], held_l);
      end
      if (rst_after >= 0 && idx == rst_after) begin
        rst[d] = 1'b1; rx_tvalid[d] = 1'b0; m_tready[d] = 1'b0;
        @(negedge clk);
        rst[d] = 1'b0;
        chk("rst_vld", m_tvalid[d], 1'b0);
        chk("rst_busy", busy[d], 1'b0);
        model_reset(m_depth);
        return;
      end
      rdy = ($urandom_range(99) < rdy_pct);
      m_tready[d] = rdy;
      if (inject && ($urandom_range(2) == 0)) begin
        rx_tvalid[d] = 1'b1; rx_tdata[d] = 8'($urandom);
        rx_tdatab[d] = 4'($urandom_range(8)); rx_tend[d] = 1'($urandom);
        inj++;
      end else rx_tvalid[d] = 1'b0;
      if (rdy) begin
        got_q.push_back(m_tdata[d]);
        chk("data", m_tdata[d], exp_q[idx]);
        chk("last", m_tlast[d], (idx == exp_q.size() - 1));
        idx++;
        held_v = 0;
      end else begin
        held_v = 1; held_d = m_tdata[d]; held_l = m_tlast[d];
      end
      @(negedge clk);
      cyc++;
    end
    rx_tvalid[d] = 1'b0; rx_tend[d] = 1'b0; rx_tdatab[d] = 4'd0; m_tready[d] = 1'b0;
    if (cyc >= 2000) chk("drain_timeout", 0, 1);
    if (rx_drop[d]) drops++;
    chk("busy_clr", busy[d], 1'b0);
    chk("vld_clr", m_tvalid[d], 1'b0);
    if (rdy_pct == 100) chk("throughput", cyc, exp_q.size());
    if (inject) begin
      @(negedge clk);
      chk("drop_idle", rx_drop[d], 1'b0);
      chk("drop_count", drops, inj);
    end
    model_reset(m_depth);
  endtask

  task automatic rand_frame(input int d, input int maxlen);
    logic [7:0] q[$];
    int n;
    logic [15:0] c;
    n = $urandom_range(maxlen);
    if ($urandom_range(2) == 0) begin
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      c = crc_of(q);
      q.push_back(c[7:0]); q.push_back(c[15:8]);
      send_bytes(d, q);
      beat(d, 8'h00, 0, 1'b1, 1'b0);
    end else begin
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(9) == 0) beat(d, 8'($urandom), $urandom_range(7), 1'b0, 1'b0);
        else                        beat(d, 8'($urandom), 8, 1'b0, 1'b0);
      end
      if ($urandom_range(1) == 0) beat(d, 8'h00, 0, 1'b1, ($urandom_range(4) == 0));
      else beat(d, 8'($urandom), $urandom_range(1, 8), 1'b1, ($urandom_range(4) == 0));
    end
    build_exp();
    drain(d, $urandom_range(40, 100), 1'($urandom), -1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] q[$];
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rx_tvalid[d] = 1'b0; rx_tdata[d] = 8'h00; rx_tdatab[d] = 4'd0;
      rx_tend[d] = 1'b0; rx_terr[d] = 1'b0; m_tready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_m_tvalid", m_tvalid[d], 1'b0);
      chk("rst_m_tdata", m_tdata[d], 8'h00);
      chk("rst_m_tlast", m_tlast[d], 1'b0);
      chk("rst_busy0", busy[d], 1'b0);
      chk("rst_rx_drop", rx_drop[d], 1'b0);
      rst[d] = 1'b0;
    end

    // good CRC
    model_reset(32);
    q = '{8'h12, 8'h34, 8'h26, 8'hCF}; send_bytes(0, q); beat(0, 8'h00, 0, 1'b1, 1'b0);
    build_exp(); drain(0, 100, 0, -1);
    chk("good_hdr", got_q[0], 8'h88); chk("good_len", got_q[1], 8'h04); chk("good_last", got_q[5], 8'hCF);

    // bad CRC, then the matching good one
    q = '{8'h00, 8'h00, 8'hA0, 8'h1F}; send_bytes(0, q); beat(0, 8'h00, 0, 1'b1, 1'b0);
    build_exp(); drain(0, 100, 0, -1);
    chk("bad_hdr", got_q[0], 8'h08); chk("bad_len", got_q[1], 8'h04);
    q = '{8'h00, 8'h00, 8'hA0, 8'h1E}; send_bytes(0, q); beat(0, 8'h00, 0, 1'b1, 1'b0);
    build_exp(); drain(0, 100, 0, -1);
    chk("good2_hdr", got_q[0], 8'h88);

    // collision
    beat(0, 8'h93, 8, 1'b0, 1'b0); beat(0, 8'h05, 3, 1'b0, 1'b0); beat(0, 8'h00, 0, 1'b1, 1'b0);
    build_exp(); drain(0, 100, 0, -1);
    chk("col_hdr", got_q[0], 8'h23); chk("col_len", got_q[1], 8'h02); chk("col_d1", got_q[3], 8'h05);

    // error end beat carrying data, then an empty frame
    beat(0, 8'h55, 8, 1'b1, 1'b1);
    build_exp(); drain(0, 100, 0, -1);
    chk("err_hdr", got_q[0], 8'h48); chk("err_len", got_q[1], 8'h01); chk("err_d0", got_q[2], 8'h55);
    beat(0, 8'h00, 0, 1'b1, 1'b0);
    build_exp(); drain(0, 100, 0, -1);
    chk("empty_size", got_q.size(), 2); chk("empty_hdr", got_q[0], 8'h00); chk("empty_len", got_q[1], 8'h00);

    // overflow on the DEPTH=4 instance
    model_reset(4);
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06}; send_bytes(1, q); beat(1, 8'h00, 0, 1'b1, 1'b0);
    build_exp(); drain(1, 100, 0, -1);
    chk("ovf_hdr", got_q[0], 8'h18); chk("ovf_len", got_q[1], 8'h04); chk("ovf_d3", got_q[5], 8'h04);

    // back-pressure with injected beats, then reset mid-DATA, then recovery
    model_reset(32);
    q = '{8'h12, 8'h34, 8'h26, 8'hCF};
    send_bytes(0, q); beat(0, 8'h00, 0, 1'b1, 1'b0);
    build_exp(); drain(0, 50, 1, -1);
    chk("bp_hdr", got_q[0], 8'h88);
    send_bytes(0, q); beat(0, 8'h00, 0, 1'b1, 1'b0);
    build_exp(); drain(0, 70, 1, 3);
    send_bytes(0, q); beat(0, 8'h00, 0, 1'b1, 1'b0);
    build_exp(); drain(0, 100, 0, -1);
    chk("post_rst_hdr", got_q[0], 8'h88);

    // randomized frames on both depths
    model_reset(32);
    for (int i = 0; i < 30; i++) rand_frame(0, 40);
    model_reset(4);
    for (int i = 0; i < 10; i++) rand_frame(1, 7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/nfca_rx_framer.md
# nfca_rx_framer

Downstream consumer of the NFC-A RX bit-to-byte stage. Collects one PICC response frame from the byte stream (one-cycle valid pulses, no back-pressure) into an internal buffer, checks CRC_A on the fly, and drains the frame to the UART/host path as a valid/ready byte stream. The stream starts with a status header byte and a length byte. It raises `busy` while a frame is held, so the NFC-A controller keeps `rx_on` low until the buffer is free.

## Interface
- `DEPTH`, 32: buffer size in bytes; 4..255.
- `clk`  in  1  system clock.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `rx_tvalid`  in  1  byte-beat strobe from the bit-to-byte stage.
- `rx_tdata`  in  8  byte value; LSB is first received.
- `rx_tdatab`  in  4  number of valid bits in `rx_tdata`, 0..8.
- `rx_tend`  in  1  end-of-frame beat.
- `rx_terr`  in  1  frame ended with an error (parity, framing or overrun).
- `m_tvalid`  out  1  output byte valid.
- `m_tready`  in  1  downstream ready.
- `m_tdata`  out  8  output byte.
- `m_tlast`  out  1  last byte of the output frame.
- `busy`  out  1  high from the end-beat capture until the final output handshake.
- `rx_drop`  out  1  one-cycle pulse when a `rx_tvalid` beat arrives while `busy` is high; the beat is discarded.

## Operation
- States are COLLECT, HDR, LEN, DATA.
- Reset:
  - State is COLLECT.
  - `count`=0, `crc`=16'h6363.
  - Flags `err`, `col`, `ovf` are 0; `lastbits`=0.
  - All outputs are 0.
- COLLECT, on each `rx_tvalid` beat:
  - If `rx_tdatab`≠0:
    - If `count`<DEPTH: write the byte at `count`, `count`++, `lastbits`←`rx_tdatab`.
    - Otherwise set `ovf` and do not store.
  - If `rx_tdatab`==8 and the byte is stored: update CRC with that byte.
  - If `rx_tend`=0 and `rx_tdatab`≠8: set `col`. This is the collision marker beat; it stores its partial byte if `rx_tdatab`>0.
  - If `rx_tend`=1: `err`←`rx_terr`, then go to HDR. The data of an end beat is stored when `rx_tdatab`≠0.
- CRC update, per byte `d`:
  - ch = d ^ crc[7:0]
  - ch = ch ^ (ch<<4), computed in 8 bits
  - crc = (crc>>8) ^ (ch<<8) ^ (ch<<3) ^ (ch>>4), computed in 16 bits
- `crc_ok` = (`crc`==0) & (`count`≥3) & (`lastbits`==8) & ~`err` & ~`col` & ~`ovf`.
- HDR: emit the header byte {crc_ok, err, col, ovf, lastbits[3:0]}.
- LEN: emit `count`.
  - `m_tlast`=1 if `count`==0, then return to COLLECT.
- DATA: emit buffer[0..count-1] in order; `m_tlast`=1 on index `count`-1.
- After the last handshake:
  - Return to COLLECT.
  - Clear `count`, flags and `lastbits`; set `crc`=16'h6363.
- Frame ends only on `rx_tend`. A collision beat is followed by a separate end beat. A bare end beat with no data (`rx_tdatab`=0) stores nothing.
- Any beat in HDR/LEN/DATA is discarded with an `rx_drop` pulse, including a beat in the same cycle as the final handshake.

## Timing
- The end beat at cycle N gives `m_tvalid`=1 with the header at N+1. `busy`=1 from N+1 through the cycle of the final handshake; it is 0 the following cycle.
- Handshake occurs when `m_tvalid` & `m_tready`. While `m_tvalid`=1 & `m_tready`=0, `m_tdata` and `m_tlast` hold stable.
- `m_tvalid` never drops without a handshake.
- Throughput is one byte per cycle with `m_tready` held high. A frame of L data bytes takes L+2 cycles to drain.
- `m_tvalid` is 0 in COLLECT.
- `rst` in any state takes effect on the next edge. Any partial or buffered frame is lost, and the next cycle shows `m_tvalid`=0 and `busy`=0.
- Overflow is sticky for the frame; `count` saturates at DEPTH.
- `rx_drop` is registered and asserts the cycle after the dropped beat.

## Test plan
- Good CRC:
  - Stimulus: beats 12,34,26,CF with `rx_tdatab`=8, then an end beat (tdatab 0, terr 0), `m_tready`=1.
  - Response: output 88,04,12,34,26,CF with `m_tlast` on CF; `busy` clears after CF.
- Bad CRC:
  - Stimulus: 00,00,A0,1F full bytes, then an end beat.
  - Response: header 08, then 04,00,00,A0,1F.
  - Also: 00,00,A0,1E gives header 88.
- Collision:
  - Stimulus: 93 (8 bits), collision beat data 05 with tdatab 3 and tend 0, then an end beat.
  - Response: header 23, len 02, then 93,05.
- Error end and empty frame:
  - Stimulus A: end beat with tend=1, terr=1, data 55, tdatab 8.
  - Response A: header 48, len 01, 55.
  - Stimulus B: a lone end beat.
  - Response B: 00,00 with `m_tlast` on the length byte.
- Overflow with DEPTH=4:
  - Stimulus: six full bytes 01..06, then an end beat.
  - Response: header 18, len 04, then 01..04.
- Back-pressure, drop and reset:
  - Stimulus: toggle `m_tready` randomly during the good-CRC frame, inject `rx_tvalid` beats while draining, and assert `rst` mid-DATA.
  - Response: the output sequence is unchanged and `rx_drop` pulses once per injected beat. After `rst`, the next cycle has `m_tvalid`=0 and `busy`=0, and a following frame drains correctly.
